encoder_scan: RTL and testbench



---
 rtl/encoder_scan_pkg.sv | 14 +
 rtl/encoder_scan_if.sv | 27 ++
 rtl/encoder_scan_lsb.sv | 23 ++
 rtl/encoder_scan.sv | 84 ++++++++
 tb/tb_encoder_scan.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/encoder_scan_pkg.sv
// Shared types and helpers for the serial LSB-first priority encoder.
package encoder_pkg;

  localparam int N_DEFAULT = 8;
  localparam int VEC_MAX   = 64;

  typedef enum logic {IDLE, SCAN} enc_state_t;

  // Callers zero-extend their vector to VEC_MAX bits.
  function automatic logic popcount_is_one(input logic [VEC_MAX-1:0] vec);
    return (vec != '0) && ((vec & (vec - VEC_MAX'(1))) == '0);
  endfunction

endpackage

// File: rtl/encoder_scan_if.sv
// Request-vector input and index-beat output handshakes of encoder_scan.
interface encoder_scan_if
  import encoder_pkg::*;
#(
  parameter int N = N_DEFAULT
);
  localparam int W = $clog2(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         out_zero;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_zero
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_zero
  );
endinterface

// File: rtl/encoder_scan_lsb.sv
// Combinational lowest-set-bit finder: binary index, isolated one-hot, any-set flag.
module lsb_priority_encoder #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         any
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

  // Two's-complement trick keeps only the lowest set bit.
  assign onehot = vec & (~vec + N'(1));
  assign any    = |vec;

endmodule

// File: rtl/encoder_scan.sv
// Serial priority encoder: captures a multi-hot vector and emits each set index, lowest first.
// state | meaning
// IDLE  | ready for a new vector, no output beat
// SCAN  | vector captured, presenting the lowest pending index
module encoder_scan
  import encoder_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  encoder_scan_if.slave  bus,
  output logic           busy
);
  localparam int W = $clog2(N);

  enc_state_t   state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         zero_flag_q, zero_flag_d;

  logic [W-1:0] enc_idx;
  logic [N-1:0] enc_onehot;
  logic         enc_any;

  lsb_priority_encoder #(.N(N), .W(W)) u_lsb (
    .vec    (pending_q),
    .idx    (enc_idx),
    .onehot (enc_onehot),
    .any    (enc_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      zero_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    zero_flag_d   = zero_flag_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    bus.out_zero  = 1'b0;
    busy          = 1'b0;

    case (state_q)
      IDLE: begin
        bus.in_ready = !rst;
        if (bus.in_valid && !rst) begin
          state_d     = SCAN;
          pending_d   = bus.in_vec;
          zero_flag_d = (bus.in_vec == '0);
        end
      end
      SCAN: begin
        bus.out_valid = 1'b1;
        busy          = 1'b1;
        bus.out_idx   = enc_any ? enc_idx : '0;
        bus.out_last  = zero_flag_q || popcount_is_one(VEC_MAX'(pending_q));
        bus.out_zero  = zero_flag_q;
        if (bus.out_ready) begin
          if (bus.out_last) begin
            state_d     = IDLE;
            pending_d   = '0;
            zero_flag_d = 1'b0;
          end else begin
            pending_d = pending_q & ~enc_onehot;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_encoder_scan.sv
// Directed bench for encoder_scan with a queue-based reference model checked every cycle.
module tb_encoder_scan;
  localparam int N = 8;
  localparam int W = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  encoder_scan_if #(.N(N)) bus ();

  encoder_scan #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int idx;
    bit last;
    bit zero;
  } beat_t;

  beat_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beat list for a vector straight from the rules: ascending set bits, last on the highest.
  task automatic model_accept(input logic [N-1:0] v);
    beat_t b;
    int hi;
    if (v == '0) begin
      b.idx = 0; b.last = 1'b1; b.zero = 1'b1;
      exp_q.push_back(b);
    end else begin
      hi = 0;
      for (int i = 0; i < N; i++) if (v[i]) hi = i;
      for (int i = 0; i < N; i++) begin
        if (v[i]) begin
          b.idx = i; b.last = (i == hi); b.zero = 1'b0;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready", int'(bus.in_ready), int'(!rst && exp_q.size() == 0));
      chk("m_out_valid", int'(bus.out_valid), int'(exp_q.size() != 0));
      chk("m_busy", int'(busy), int'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("m_out_idx", int'(bus.out_idx), exp_q[0].idx);
        chk("m_out_last", int'(bus.out_last), int'(exp_q[0].last));
        chk("m_out_zero", int'(bus.out_zero), int'(exp_q[0].zero));
      end
      if (rst) exp_q.delete();
      else if (exp_q.size() == 0) begin
        if (bus.in_valid) model_accept(bus.in_vec);
      end else if (bus.out_ready) void'(exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(bus.in_ready), 1);

    // Single bit
    bus.in_valid = 1'b1; bus.in_vec = 8'b0010_0000;
    tick();
    bus.in_valid = 1'b0;
    chk("single_idx", int'(bus.out_idx), 5);
    chk("single_last", int'(bus.out_last), 1);
    chk("single_zero", int'(bus.out_zero), 0);
    tick();
    chk("single_in_ready", int'(bus.in_ready), 1);
    chk("single_out_valid", int'(bus.out_valid), 0);

    // Multi-hot stream
    bus.in_valid = 1'b1; bus.in_vec = 8'b1001_0110;
    tick();
    bus.in_valid = 1'b0;
    chk("multi_idx0", int'(bus.out_idx), 1); chk("multi_last0", int'(bus.out_last), 0);
    tick();
    chk("multi_idx1", int'(bus.out_idx), 2); chk("multi_last1", int'(bus.out_last), 0);
    tick();
    chk("multi_idx2", int'(bus.out_idx), 4); chk("multi_last2", int'(bus.out_last), 0);
    tick();
    chk("multi_idx3", int'(bus.out_idx), 7); chk("multi_last3", int'(bus.out_last), 1);
    tick();
    chk("multi_busy_done", int'(busy), 0);

    // Backpressure
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_vec = 8'b0000_1001;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_idx", int'(bus.out_idx), 0);
      chk("bp_hold_last", int'(bus.out_last), 0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rel_idx0", int'(bus.out_idx), 0);
    tick();
    chk("bp_rel_idx1", int'(bus.out_idx), 3);
    chk("bp_rel_last1", int'(bus.out_last), 1);
    tick();
    chk("bp_idle", int'(bus.out_valid), 0);

    // Zero vector
    bus.in_valid = 1'b1; bus.in_vec = 8'h00;
    tick();
    bus.in_valid = 1'b0;
    chk("zero_valid", int'(bus.out_valid), 1);
    chk("zero_idx", int'(bus.out_idx), 0);
    chk("zero_last", int'(bus.out_last), 1);
    chk("zero_zero", int'(bus.out_zero), 1);
    tick();
    chk("zero_idle", int'(bus.out_valid), 0);

    // All ones then back-to-back 0x80 held during the scan
    bus.in_valid = 1'b1; bus.in_vec = 8'hFF;
    tick();
    bus.in_vec = 8'h80;
    for (int k = 0; k < N; k++) begin
      chk("ones_idx", int'(bus.out_idx), k);
      chk("ones_last", int'(bus.out_last), int'(k == N - 1));
      chk("ones_in_ready", int'(bus.in_ready), 0);
      tick();
    end
    chk("b2b_gap_in_ready", int'(bus.in_ready), 1);
    chk("b2b_gap_out_valid", int'(bus.out_valid), 0);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_idx", int'(bus.out_idx), 7);
    chk("b2b_last", int'(bus.out_last), 1);
    tick();
    chk("b2b_idle", int'(bus.out_valid), 0);

    // Reset mid-scan
    bus.in_valid = 1'b1; bus.in_vec = 8'b1110_0000;
    tick();
    bus.in_valid = 1'b0;
    chk("mid_first_idx", int'(bus.out_idx), 5);
    rst = 1'b1;
    tick();
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    rst = 1'b0;
    #1;
    chk("mid_after_in_ready", int'(bus.in_ready), 1);
    tick();
    chk("mid_no_more_beats", int'(bus.out_valid), 0);
    bus.in_valid = 1'b1; bus.in_vec = 8'h01;
    tick();
    bus.in_valid = 1'b0;
    chk("mid_new_idx", int'(bus.out_idx), 0);
    chk("mid_new_last", int'(bus.out_last), 1);
    chk("mid_new_zero", int'(bus.out_zero), 0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
